// File: rtl/prf_wb_arbiter.sv
// Writeback scheduler for the physical register file: per-requester result FIFOs
// feeding NPORT registered PRF/ROB writeback ports through a round-robin arbiter.
module prf_wb_arbiter #(
   parameter int NREQ   = 3,
   parameter int NPORT  = 2,
   parameter int DEPTH  = 2,
   parameter int PREG_W = 7,
   parameter int ROB_W  = 4,
   parameter int DATA_W = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*PREG_W-1:0]    req_prd,
   input  logic [NREQ*ROB_W-1:0]     req_rob,
   input  logic [NREQ*DATA_W-1:0]    req_data,
   output logic [NPORT-1:0]          wb_valid,
   output logic [NPORT*PREG_W-1:0]   wb_prd,
   output logic [NPORT*ROB_W-1:0]    wb_rob,
   output logic [NPORT*DATA_W-1:0]   wb_data
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   // FIFO state
   logic [PTR_W-1:0]  rd_ptr_q [NREQ];
   logic [PTR_W-1:0]  rd_ptr_d [NREQ];
   logic [PTR_W-1:0]  wr_ptr_q [NREQ];
   logic [PTR_W-1:0]  wr_ptr_d [NREQ];
   logic [CNT_W-1:0]  cnt_q    [NREQ];
   logic [CNT_W-1:0]  cnt_d    [NREQ];

   logic [PREG_W-1:0] mem_prd_q  [NREQ][DEPTH];
   logic [ROB_W-1:0]  mem_rob_q  [NREQ][DEPTH];
   logic [DATA_W-1:0] mem_data_q [NREQ][DEPTH];

   logic [PREG_W-1:0] head_prd  [NREQ];
   logic [ROB_W-1:0]  head_rob  [NREQ];
   logic [DATA_W-1:0] head_data [NREQ];

   logic [NREQ-1:0]   full;
   logic [NREQ-1:0]   empty;
   logic [NREQ-1:0]   push;
   logic [NREQ-1:0]   pop;
   logic              clear;

   // Arbiter state
   logic [IDX_W-1:0]  rr_ptr_q;
   logic [IDX_W-1:0]  rr_ptr_d;
   logic [NPORT-1:0]  port_vld;
   logic [IDX_W-1:0]  port_src [NPORT];

   // Writeback stage
   logic [NPORT-1:0]        wb_valid_q;
   logic [NPORT-1:0]        wb_valid_d;
   logic [NPORT*PREG_W-1:0] wb_prd_q;
   logic [NPORT*PREG_W-1:0] wb_prd_d;
   logic [NPORT*ROB_W-1:0]  wb_rob_q;
   logic [NPORT*ROB_W-1:0]  wb_rob_d;
   logic [NPORT*DATA_W-1:0] wb_data_q;
   logic [NPORT*DATA_W-1:0] wb_data_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign clear = reset | flush;

   // Ready depends only on registered occupancy, so a full FIFO stays not-ready
   // even in a cycle where it is also being popped.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         full[i]      = (cnt_q[i] == CNT_W'(DEPTH));
         empty[i]     = (cnt_q[i] == '0);
         req_ready[i] = ~full[i];
         push[i]      = req_valid[i] & ~full[i] & ~clear;
         head_prd[i]  = mem_prd_q[i][rd_ptr_q[i]];
         head_rob[i]  = mem_rob_q[i][rd_ptr_q[i]];
         head_data[i] = mem_data_q[i][rd_ptr_q[i]];
      end
   end

   // Round-robin scan from rr_ptr; successive non-empty heads fill ports 0, 1, ...
   always_comb begin
      int gcnt;
      int sel;
      // NOTE: every always_comb output gets a default before any conditional
      // assignment, otherwise an unassigned path infers a latch.
      gcnt     = 0;
      sel      = 0;
      pop      = '0;
      port_vld = '0;
      rr_ptr_d = rr_ptr_q;
      for (int p = 0; p < NPORT; p++) begin
         port_src[p] = '0;
      end
      for (int k = 0; k < NREQ; k++) begin
         sel = int'(rr_ptr_q) + k;
         if (sel >= NREQ) begin
            sel = sel - NREQ;
         end
         for (int i = 0; i < NREQ; i++) begin
            if (sel == i && !empty[i] && gcnt < NPORT) begin
               pop[i] = 1'b1;
               for (int p = 0; p < NPORT; p++) begin
                  if (gcnt == p) begin
                     port_vld[p] = 1'b1;
                     port_src[p] = IDX_W'(i);
                  end
               end
               rr_ptr_d = (i == NREQ - 1) ? '0 : IDX_W'(i + 1);
               gcnt     = gcnt + 1;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         rd_ptr_d[i] = pop[i]  ? ptr_inc(rd_ptr_q[i]) : rd_ptr_q[i];
         wr_ptr_d[i] = push[i] ? ptr_inc(wr_ptr_q[i]) : wr_ptr_q[i];
         case ({push[i], pop[i]})
            2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
            2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
            default: cnt_d[i] = cnt_q[i];
         endcase
      end
   end

   // Idle ports only drop valid; their payload fields keep the last value.
   always_comb begin
      wb_valid_d = port_vld;
      wb_prd_d   = wb_prd_q;
      wb_rob_d   = wb_rob_q;
      wb_data_d  = wb_data_q;
      for (int p = 0; p < NPORT; p++) begin
         if (port_vld[p]) begin
            wb_prd_d[p*PREG_W +: PREG_W]  = head_prd[port_src[p]];
            wb_rob_d[p*ROB_W +: ROB_W]    = head_rob[port_src[p]];
            wb_data_d[p*DATA_W +: DATA_W] = head_data[port_src[p]];
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < NREQ; i++) begin
            rd_ptr_q[i] <= '0;
            wr_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
         rr_ptr_q   <= '0;
         wb_valid_q <= '0;
         if (reset) begin
            wb_prd_q  <= '0;
            wb_rob_q  <= '0;
            wb_data_q <= '0;
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            rd_ptr_q[i] <= rd_ptr_d[i];
            wr_ptr_q[i] <= wr_ptr_d[i];
            cnt_q[i]    <= cnt_d[i];
         end
         rr_ptr_q   <= rr_ptr_d;
         wb_valid_q <= wb_valid_d;
         wb_prd_q   <= wb_prd_d;
         wb_rob_q   <= wb_rob_d;
         wb_data_q  <= wb_data_d;
      end
   end

   // NOTE: FIFO storage has no reset; an entry is only read after the count
   // says it was written, so clearing the pointers and counts is enough.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NREQ; i++) begin
         if (push[i]) begin
            mem_prd_q[i][wr_ptr_q[i]]  <= req_prd[i*PREG_W +: PREG_W];
            mem_rob_q[i][wr_ptr_q[i]]  <= req_rob[i*ROB_W +: ROB_W];
            mem_data_q[i][wr_ptr_q[i]] <= req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign wb_valid = wb_valid_q;
   assign wb_prd   = wb_prd_q;
   assign wb_rob   = wb_rob_q;
   assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Directed bench for prf_wb_arbiter: a table of per-cycle stimulus with
// hand-derived expected writeback sources, plus short hand-written sequences.
module tb_prf_wb_arbiter;

   localparam int NREQ   = 3;
   localparam int NPORT  = 2;
   localparam int PREG_W = 7;
   localparam int ROB_W  = 4;
   localparam int DATA_W = 32;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     flush;
   logic [NREQ-1:0]          req_valid;
   logic [NREQ-1:0]          req_ready;
   logic [NREQ*PREG_W-1:0]   req_prd;
   logic [NREQ*ROB_W-1:0]    req_rob;
   logic [NREQ*DATA_W-1:0]   req_data;
   logic [NPORT-1:0]         wb_valid;
   logic [NPORT*PREG_W-1:0]  wb_prd;
   logic [NPORT*ROB_W-1:0]   wb_rob;
   logic [NPORT*DATA_W-1:0]  wb_data;

   int n_checks = 0;
   int n_errors = 0;

   prf_wb_arbiter #(
      .NREQ(NREQ), .NPORT(NPORT), .DEPTH(2),
      .PREG_W(PREG_W), .ROB_W(ROB_W), .DATA_W(DATA_W)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_prd(req_prd), .req_rob(req_rob), .req_data(req_data),
      .wb_valid(wb_valid), .wb_prd(wb_prd), .wb_rob(wb_rob), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   // One row = inputs for one cycle and the expected outputs after that edge.
   // s0/t0 and s1/t1 name the (requester, tag) expected on ports 0 and 1.
   typedef struct packed {
      logic       rst;
      logic       fl;
      logic [2:0] v;
      logic [3:0] tag;
      logic [2:0] rdy;
      logic [1:0] wv;
      logic [1:0] s0;
      logic [3:0] t0;
      logic [1:0] s1;
      logic [3:0] t1;
   } vec_t;

   vec_t vq[$];
   vec_t cur;

   function automatic logic [PREG_W-1:0] enc_prd(input int s, input int t);
      return {1'b1, 2'(s), 4'(t)};
   endfunction

   function automatic logic [ROB_W-1:0] enc_rob(input int s, input int t);
      return 4'(t + 5 * s);
   endfunction

   function automatic logic [DATA_W-1:0] enc_data(input int s, input int t);
      return {16'hBEEF, 4'(s), 4'(t), 8'(255 - t)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic fl, input logic [2:0] v, input int tag,
                      input logic [2:0] rdy, input logic [1:0] wv,
                      input int s0, input int t0, input int s1, input int t1);
      vec_t x;
      x.rst = rst;  x.fl = fl;  x.v = v;  x.tag = 4'(tag);
      x.rdy = rdy;  x.wv = wv;
      x.s0 = 2'(s0); x.t0 = 4'(t0); x.s1 = 2'(s1); x.t1 = 4'(t1);
      vq.push_back(x);
   endtask

   task automatic drive_row(input vec_t x);
      reset     = x.rst;
      flush     = x.fl;
      req_valid = x.v;
      for (int i = 0; i < NREQ; i++) begin
         req_prd[i*PREG_W +: PREG_W]  = enc_prd(i, int'(x.tag));
         req_rob[i*ROB_W +: ROB_W]    = enc_rob(i, int'(x.tag));
         req_data[i*DATA_W +: DATA_W] = enc_data(i, int'(x.tag));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      req_valid = '0;
      req_prd   = '0;
      req_rob   = '0;
      req_data  = '0;

      // Reset for two cycles, then a single ALU result with 2-edge latency.
      for (int c = 0; c < 2; c++) begin
         tick();
         check($sformatf("rst%0d ready", c), 32'(req_ready), 32'h7);
         check($sformatf("rst%0d wb_valid", c), 32'(wb_valid), 32'h0);
         check($sformatf("rst%0d wb_prd", c), 32'(wb_prd), 32'h0);
         check($sformatf("rst%0d wb_rob", c), 32'(wb_rob), 32'h0);
         check($sformatf("rst%0d wb_data0", c), wb_data[31:0], 32'h0);
      end
      reset = 1'b0;
      tick();
      check("post_rst ready", 32'(req_ready), 32'h7);
      check("post_rst wb_valid", 32'(wb_valid), 32'h0);
      req_valid = 3'b001;
      req_prd[6:0] = 7'd5;
      req_rob[3:0] = 4'd3;
      req_data[31:0] = 32'h0000_1234;
      tick();
      check("alu E0 wb_valid", 32'(wb_valid), 32'h0);
      req_valid = '0;
      tick();
      check("alu E1 wb_valid", 32'(wb_valid), 32'h1);
      check("alu E1 wb_prd0", 32'(wb_prd[6:0]), 32'd5);
      check("alu E1 wb_rob0", 32'(wb_rob[3:0]), 32'd3);
      check("alu E1 wb_data0", wb_data[31:0], 32'h0000_1234);
      tick();
      check("alu E2 wb_valid", 32'(wb_valid), 32'h0);

      // Three requesters pushing every cycle: pairs rotate (0,1),(2,0),(1,2).
      add(1, 0, 3'b000, 0, 3'b111, 2'b00, 0, 0, 0, 0);
      add(1, 0, 3'b000, 0, 3'b111, 2'b00, 0, 0, 0, 0);
      add(0, 0, 3'b111, 0, 3'b111, 2'b00, 0, 0, 0, 0);
      add(0, 0, 3'b111, 1, 3'b011, 2'b11, 0, 0, 1, 0);
      add(0, 0, 3'b111, 2, 3'b101, 2'b11, 2, 0, 0, 1);
      add(0, 0, 3'b111, 3, 3'b110, 2'b11, 1, 1, 2, 1);
      add(0, 0, 3'b111, 4, 3'b011, 2'b11, 0, 2, 1, 2);
      add(0, 0, 3'b111, 5, 3'b101, 2'b11, 2, 3, 0, 3);
      add(0, 0, 3'b000, 0, 3'b111, 2'b11, 1, 4, 2, 4);
      add(0, 0, 3'b000, 0, 3'b111, 2'b11, 0, 5, 1, 5);
      add(0, 0, 3'b000, 0, 3'b111, 2'b00, 0, 0, 0, 0);
      // LSU fills while ALU/BRU hold priority; third LSU result waits for a pop.
      add(1, 0, 3'b000, 0, 3'b111, 2'b00, 0, 0, 0, 0);
      add(0, 0, 3'b111, 8, 3'b111, 2'b00, 0, 0, 0, 0);
      add(0, 0, 3'b100, 9, 3'b011, 2'b11, 0, 8, 1, 8);
      add(0, 0, 3'b100, 10, 3'b111, 2'b01, 2, 8, 0, 0);
      add(0, 0, 3'b100, 10, 3'b111, 2'b01, 2, 9, 0, 0);
      add(0, 0, 3'b000, 0, 3'b111, 2'b01, 2, 10, 0, 0);
      add(0, 0, 3'b000, 0, 3'b111, 2'b00, 0, 0, 0, 0);
      // BRU streams 5 results with push and pop each cycle across pointer wrap.
      add(0, 0, 3'b010, 1, 3'b111, 2'b00, 0, 0, 0, 0);
      add(0, 0, 3'b010, 2, 3'b111, 2'b01, 1, 1, 0, 0);
      add(0, 0, 3'b010, 3, 3'b111, 2'b01, 1, 2, 0, 0);
      add(0, 0, 3'b010, 4, 3'b111, 2'b01, 1, 3, 0, 0);
      add(0, 0, 3'b010, 5, 3'b111, 2'b01, 1, 4, 0, 0);
      add(0, 0, 3'b000, 0, 3'b111, 2'b01, 1, 5, 0, 0);
      add(0, 0, 3'b000, 0, 3'b111, 2'b00, 0, 0, 0, 0);
      // Flush with loaded FIFOs and a concurrent push: nothing may emerge.
      add(0, 0, 3'b111, 11, 3'b111, 2'b00, 0, 0, 0, 0);
      add(0, 0, 3'b111, 12, 3'b101, 2'b11, 2, 11, 0, 11);
      add(0, 1, 3'b111, 13, 3'b111, 2'b00, 0, 0, 0, 0);
      add(0, 0, 3'b000, 0, 3'b111, 2'b00, 0, 0, 0, 0);
      add(0, 0, 3'b000, 0, 3'b111, 2'b00, 0, 0, 0, 0);
      // Reset mid-burst behaves like flush.
      add(0, 0, 3'b111, 14, 3'b111, 2'b00, 0, 0, 0, 0);
      add(1, 0, 3'b111, 15, 3'b111, 2'b00, 0, 0, 0, 0);
      add(0, 0, 3'b000, 0, 3'b111, 2'b00, 0, 0, 0, 0);
      add(0, 0, 3'b000, 0, 3'b111, 2'b00, 0, 0, 0, 0);

      for (int r = 0; r < vq.size(); r++) begin
         cur = vq[r];
         drive_row(cur);
         tick();
         check($sformatf("row%0d ready", r), 32'(req_ready), 32'(cur.rdy));
         check($sformatf("row%0d wb_valid", r), 32'(wb_valid), 32'(cur.wv));
         for (int p = 0; p < NPORT; p++) begin
            if (cur.wv[p]) begin
               int s;
               int t;
               s = (p == 0) ? int'(cur.s0) : int'(cur.s1);
               t = (p == 0) ? int'(cur.t0) : int'(cur.t1);
               check($sformatf("row%0d wb_prd%0d", r, p),
                     32'(wb_prd[p*PREG_W +: PREG_W]), 32'(enc_prd(s, t)));
               check($sformatf("row%0d wb_rob%0d", r, p),
                     32'(wb_rob[p*ROB_W +: ROB_W]), 32'(enc_rob(s, t)));
               check($sformatf("row%0d wb_data%0d", r, p),
                     wb_data[p*DATA_W +: DATA_W], enc_data(s, t));
            end
         end
      end

      // prd == 0 still completes the handshake and writes back for the ROB.
      reset     = 1'b0;
      flush     = 1'b0;
      req_valid = 3'b001;
      req_prd   = '0;
      req_rob   = '0;
      req_data  = '0;
      req_rob[3:0]   = 4'd7;
      req_data[31:0] = 32'hCAFE_0007;
      tick();
      check("prd0 accept ready", 32'(req_ready), 32'h7);
      check("prd0 E0 wb_valid", 32'(wb_valid), 32'h0);
      req_valid = '0;
      tick();
      check("prd0 E1 wb_valid", 32'(wb_valid), 32'h1);
      check("prd0 E1 wb_prd0", 32'(wb_prd[6:0]), 32'd0);
      check("prd0 E1 wb_rob0", 32'(wb_rob[3:0]), 32'd7);
      check("prd0 E1 wb_data0", wb_data[31:0], 32'hCAFE_0007);
      tick();
      check("prd0 E2 wb_valid", 32'(wb_valid), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
